// File: rtl/as_imem_load_ctrl.sv
// I-Mem initial-load sequencer: buffers scan words, writes them to I-Mem, holds the core in reset.
// Optional AS_IMEM_VERIFY_EN adds a read-back VERIFY cycle after every write.
module as_imem_load_ctrl #(
    parameter int IMEM_AW    = 10,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RST_CYCLES = 10
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               load_req_i,
    input  logic               scan_valid_i,
    input  logic [IMEM_AW-1:0] scan_addr_i,
    input  logic [DW-1:0]      scan_data_i,
    output logic               scan_ready_o,
    input  logic [IMEM_AW-1:0] core_addr_i,
    output logic [DW-1:0]      core_data_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic [DW-1:0]      imem_wdata_o,
    output logic               imem_we_o,
    input  logic [DW-1:0]      imem_rdata_i,
    output logic               core_rst_o,
    output logic               loading_o,
    output logic [IMEM_AW:0]   load_cnt_o,
    output logic               ovf_o,
    output logic               verify_err_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(RST_CYCLES + 1);
    localparam logic [PW:0]      DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [IMEM_AW:0] CNT_MAX = {1'b1, {IMEM_AW{1'b0}}};
    localparam logic [CW-1:0]    HOLD_C  = CW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_LOAD, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      hcnt_q;
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PW:0]        cnt_q;
    logic [IMEM_AW-1:0] f_addr [FIFO_DEPTH];
    logic [DW-1:0]      f_data [FIFO_DEPTH];
    logic [IMEM_AW:0]   load_cnt_q;
    logic               ovf_q;
    logic               full, empty, active, push, pop, drop, load_entry, vfy_busy;

    assign full         = (cnt_q == DEPTH_C);
    assign empty        = (cnt_q == '0);
    assign active       = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign scan_ready_o = (state_q == S_LOAD) && !full;
    assign push         = scan_valid_i && scan_ready_o;
    assign drop         = scan_valid_i && !scan_ready_o;
    assign pop          = active && !empty && !vfy_busy;
    assign load_entry   = (state_q == S_RUN) && load_req_i;

`ifdef AS_IMEM_VERIFY_EN
    logic               vfy_q, verr_q;
    logic [IMEM_AW-1:0] vfy_addr_q;
    logic [DW-1:0]      vfy_data_q;

    // The cycle after a write re-reads the same address and compares.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vfy_q      <= 1'b0;
            verr_q     <= 1'b0;
            vfy_addr_q <= '0;
            vfy_data_q <= '0;
        end else begin
            vfy_q <= pop;
            if (pop) begin
                vfy_addr_q <= f_addr[rd_ptr_q];
                vfy_data_q <= f_data[rd_ptr_q];
            end
            if (load_entry)
                verr_q <= 1'b0;
            else if (vfy_q && (imem_rdata_i != vfy_data_q))
                verr_q <= 1'b1;
        end
    end
    assign vfy_busy     = vfy_q;
    assign verify_err_o = verr_q;
`else
    assign vfy_busy     = 1'b0;
    assign verify_err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HOLD:  if (hcnt_q == '0) state_d = S_RUN;
            S_RUN:   if (load_req_i) state_d = S_LOAD;
            S_LOAD:  if (!load_req_i) state_d = S_DRAIN;
            S_DRAIN: if (empty && !vfy_busy) state_d = S_HOLD;
            default: state_d = S_HOLD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_HOLD;
            hcnt_q     <= HOLD_C;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            load_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DRAIN && state_d == S_HOLD)
                hcnt_q <= HOLD_C;
            else if (state_q == S_HOLD && hcnt_q != '0)
                hcnt_q <= hcnt_q - 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (load_entry)
                load_cnt_q <= '0;
            else if (pop && load_cnt_q != CNT_MAX)
                load_cnt_q <= load_cnt_q + 1'b1;
            // A drop in the same cycle as load entry is still reported.
            if (drop)
                ovf_q <= 1'b1;
            else if (load_entry)
                ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            f_addr[wr_ptr_q] <= scan_addr_i;
            f_data[wr_ptr_q] <= scan_data_i;
        end
    end

    always_comb begin
        imem_addr_o  = f_addr[rd_ptr_q];
        imem_wdata_o = f_data[rd_ptr_q];
        core_data_o  = DW'(32'h0000_0013);
        if (state_q == S_RUN) begin
            imem_addr_o = core_addr_i;
            core_data_o = imem_rdata_i;
        end else if (vfy_busy) begin
`ifdef AS_IMEM_VERIFY_EN
            imem_addr_o = vfy_addr_q;
`endif
        end
    end

    assign imem_we_o  = pop;
    assign core_rst_o = (state_q != S_RUN);
    assign loading_o  = active;
    assign load_cnt_o = load_cnt_q;
    assign ovf_o      = ovf_q;
endmodule

// File: tb/tb_as_imem_load_ctrl.sv
// Randomized self-checking bench for as_imem_load_ctrl against a queue/array reference model.
module tb_as_imem_load_ctrl;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int RSTC = 10;
`ifdef AS_IMEM_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic load_req = 1'b0, scan_valid = 1'b0, scan_ready;
    logic [AW-1:0] scan_addr = '0, core_addr = '0, imem_addr;
    logic [DW-1:0] scan_data = '0, core_data, imem_wdata, imem_rdata;
    logic imem_we, core_rst, loading, ovf, verr;
    logic [AW:0] load_cnt;
    logic corrupt = 1'b0;

    logic [DW-1:0] mem [1024];
    logic [DW-1:0] ref_mem [1024];
    logic [AW-1:0] sb_addr [$];
    logic [DW-1:0] sb_data [$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    as_imem_load_ctrl #(.IMEM_AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH), .RST_CYCLES(RSTC)) dut (
        .clk_i(clk), .rstn_i(rstn), .load_req_i(load_req), .scan_valid_i(scan_valid),
        .scan_addr_i(scan_addr), .scan_data_i(scan_data), .scan_ready_o(scan_ready),
        .core_addr_i(core_addr), .core_data_o(core_data), .imem_addr_o(imem_addr),
        .imem_wdata_o(imem_wdata), .imem_we_o(imem_we), .imem_rdata_i(imem_rdata),
        .core_rst_o(core_rst), .loading_o(loading), .load_cnt_o(load_cnt),
        .ovf_o(ovf), .verify_err_o(verr));

    // Bench memory: combinational read, optional corruption of address 7 on read.
    assign imem_rdata = mem[imem_addr] ^ ((corrupt && imem_addr == 10'd7) ? 32'h1 : 32'h0);
    always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Every observed write must be the next expected accepted word.
    always @(negedge clk) begin
        if (rstn && imem_we) begin
            if (sb_addr.size() == 0) chk("unexp_wr", 1, 0);
            else begin
                chk("wr_addr", 64'(imem_addr), 64'(sb_addr.pop_front()));
                chk("wr_data", 64'(imem_wdata), 64'(sb_data.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic hold_len(input string tag);
        int n = 0;
        while (core_rst && n < 100) begin n++; tick(); end
        chk(tag, 64'(n), 64'(RSTC));
    endtask

    task automatic enter_load();
        load_req = 1'b1;
        tick();
        chk("load_ent", {61'b0, loading, core_rst, scan_ready}, 64'b111);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit accepted);
        scan_valid = 1'b1; scan_addr = a; scan_data = d;
        if (accepted) begin
            sb_addr.push_back(a); sb_data.push_back(d); ref_mem[a] = d;
        end
        tick();
        scan_valid = 1'b0;
    endtask

    task automatic finish_load();
        int n = 0;
        load_req = 1'b0;
        while (loading && n < 200) begin n++; tick(); end
        chk("drain_to", 64'(loading), 0);
        chk("sb_empty", 64'(sb_addr.size()), 0);
        hold_len("hold_after_load");
    endtask

    // Accept mask for n back-to-back pulses starting in an idle LOAD.
    function automatic logic [15:0] burst_mask(input int n);
        int occ = 0; bit busy = 0; bit p; logic [15:0] m = '0;
        for (int i = 0; i < n; i++) begin
            p = (occ > 0) && !(VFY && busy);
            m[i] = (occ < DEPTH);
            occ = occ + int'(m[i]) - int'(p);
            busy = p;
        end
        return m;
    endfunction

    initial begin
        logic [15:0] m;
        int n, acc;
        logic [AW-1:0] a, last_a;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'(i) * 32'h0101_0101 ^ 32'h5a5a_0000;
            ref_mem[i] = mem[i];
        end
        repeat (3) tick();
        chk("rst_state", {57'b0, core_rst, imem_we, scan_ready, loading, ovf, verr, |load_cnt},
            64'b1000000);
        rstn = 1'b1;
        hold_len("hold_por");

        // RUN: core fetch passes through.
        core_addr = 10'd5; #1;
        chk("run_fetch", 64'(core_data), 64'(ref_mem[5]));
        chk("run_addr", 64'(imem_addr), 5);

        // Directed 3-word program.
        enter_load();
        send(10'd0, 32'h0050_0093, 1'b1);
        send(10'd1, 32'h0010_0113, 1'b1);
        send(10'd2, 32'h0020_81b3, 1'b1);
        chk("nop_in_load", 64'(core_data), 64'h13);
        finish_load();
        chk("cnt3", 64'(load_cnt), 3);
        core_addr = 10'd2; #1;
        chk("fetch2", 64'(core_data), 64'h0020_81b3);

        // Randomized spaced loads: every word accepted.
        for (int l = 0; l < 4; l++) begin
            n = $urandom_range(1, 6);
            enter_load();
            for (int k = 0; k < n; k++) begin
                a = 10'($urandom_range(8, 1023));
                last_a = a;
                send(a, $urandom, 1'b1);
                repeat ($urandom_range(1, 3)) tick();
            end
            finish_load();
            chk("rnd_cnt", 64'(load_cnt), 64'(n));
            chk("rnd_ovf", 64'(ovf), 0);
            core_addr = last_a; #1;
            chk("rnd_fetch", 64'(core_data), 64'(ref_mem[last_a]));
        end

        // Back-to-back burst of 10 pulses.
        m = burst_mask(10);
        acc = 0;
        enter_load();
        for (int k = 0; k < 10; k++) begin
            send(10'(100 + k), $urandom, m[k]);
            acc += int'(m[k]);
        end
        finish_load();
        chk("burst_cnt", 64'(load_cnt), 64'(acc));
        chk("burst_ovf", 64'(ovf), 64'(acc != 10));

        // Read-back corruption on address 7.
        corrupt = 1'b1;
        enter_load();
        send(10'd3, 32'h1111_2222, 1'b1);
        repeat (3) tick();
        chk("verr_a3", 64'(verr), 0);
        send(10'd7, 32'h3333_4444, 1'b1);
        repeat (3) tick();
        chk("verr_a7", 64'(verr), 64'(VFY));
        send(10'd9, 32'h5555_6666, 1'b1);
        finish_load();
        corrupt = 1'b0;
        chk("verr_sticky", 64'(verr), 64'(VFY));

        // Reset during a write aborts it immediately.
        enter_load();
        chk("verr_clr", 64'(verr), 0);
        scan_valid = 1'b1; scan_addr = 10'd20; scan_data = 32'hdead_0001;
        tick();
        scan_valid = 1'b0;
        chk("wr_before_rst", 64'(imem_we), 1);
        rstn = 1'b0;
        #1;
        chk("we_async", 64'(imem_we), 0);
        chk("rst_mid", {60'b0, core_rst, loading, ovf, |load_cnt}, 64'b1000);
        load_req = 1'b0;
        tick();
        rstn = 1'b1;
        hold_len("hold_rst2");
        enter_load();
        repeat (4) tick();
        chk("fifo_empty_cnt", 64'(load_cnt), 0);
        finish_load();
        chk("mem20_unwritten", 64'(mem[20]), 64'(ref_mem[20]));

        // Scan pulse during RUN is dropped.
        core_addr = 10'd5;
        send(10'd5, 32'hbeef_beef, 1'b0);
        chk("run_ovf", 64'(ovf), 1);
        chk("run_undisturbed", 64'(core_data), 64'(ref_mem[5]));
        chk("run_we", 64'(imem_we), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
